div_sched: RTL

DIV_SCHED -- requirements
Module: div_sched

---
 rtl/div_sched_pkg.sv | 17 +
 rtl/div_restoring_step.sv | 23 ++
 rtl/div_sched.sv | 132 +++++++++++++
 3 files changed

// File: rtl/div_sched_pkg.sv
// Shared types and width constants for the two-requester iterative divider.
package div_sched_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DVD_W  = 16;
    localparam int QW     = DVD_W / 2;
    localparam int PREM_W = QW + 1;
    localparam int ITERS  = 16;
    localparam int CNT_W  = 5;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    typedef logic req_id_t;
endpackage

// File: rtl/div_restoring_step.sv
// One combinational restoring-division step: shift, trial subtract, restore on negative.
module div_restoring_step
    import div_sched_pkg::*;
(
    input  logic [PREM_W-1:0] prem_i,
    input  logic [DVD_W-1:0]  dvd_i,
    input  logic [QW-1:0]     dvs_i,
    output logic [PREM_W-1:0] prem_o,
    output logic [DVD_W-1:0]  dvd_o
);
    logic [PREM_W:0] shifted;
    logic [PREM_W:0] diff;
    logic            neg;

    // The partial remainder stays below the divisor, so the shifted value never
    // reaches bit PREM_W and a set top bit of diff means the subtraction went negative.
    assign shifted = {prem_i, dvd_i[DVD_W-1]};
    assign diff    = shifted - {2'b00, dvs_i};
    assign neg     = diff[PREM_W];

    assign prem_o = neg ? shifted[PREM_W-1:0] : diff[PREM_W-1:0];
    assign dvd_o  = {dvd_i[DVD_W-2:0], ~neg};
endmodule

// File: rtl/div_sched.sv
// Round-robin front end sharing one 16/8 restoring divider between two requesters.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH/2-1:0] req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH/2-1:0] req1_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH/2-1:0] rsp_quot,
    output logic [WIDTH/2-1:0] rsp_rem,
    output logic               rsp_ovf,
    output logic               rsp_dbz,
    output logic               busy
);
    state_e             state_q;
    logic [DVD_W-1:0]   dvd_q;
    logic [QW-1:0]      dvs_q;
    logic [PREM_W-1:0]  prem_q;
    logic [CNT_W-1:0]   cnt_q;
    req_id_t            id_q;
    req_id_t            last_q;
    logic               rsp_valid_q, rsp_id_q, rsp_ovf_q, rsp_dbz_q;
    logic [QW-1:0]      rsp_quot_q, rsp_rem_q;

    logic [PREM_W-1:0]  prem_d;
    logic [DVD_W-1:0]   dvd_d;
    logic               idle, acc0, acc1, acc_any;
    req_id_t            acc_id;
    logic [DVD_W-1:0]   acc_a;
    logic [QW-1:0]      acc_b;

    div_restoring_step u_step (
        .prem_i (prem_q),
        .dvd_i  (dvd_q),
        .dvs_i  (dvs_q),
        .prem_o (prem_d),
        .dvd_o  (dvd_d)
    );

    // On a tie the requester that was not granted last wins.
    assign idle       = (state_q == IDLE);
    assign req0_ready = idle && req0_valid && (!req1_valid || last_q);
    assign req1_ready = idle && req1_valid && (!req0_valid || !last_q);
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;
    assign acc_any    = acc0 || acc1;
    assign acc_id     = acc1;
    assign acc_a      = acc1 ? req1_a : req0_a;
    assign acc_b      = acc1 ? req1_b : req0_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            cnt_q       <= '0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_quot_q  <= '0;
            rsp_rem_q   <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (acc_any) begin
                        last_q <= acc_id;
                        id_q   <= acc_id;
                        dvd_q  <= acc_a;
                        dvs_q  <= acc_b;
                        prem_q <= '0;
                        cnt_q  <= '0;
                        if (acc_b == '0) begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_id_q    <= acc_id;
                            rsp_quot_q  <= '1;
                            rsp_rem_q   <= '0;
                            rsp_ovf_q   <= 1'b0;
                            rsp_dbz_q   <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem_q <= prem_d;
                    dvd_q  <= dvd_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_quot_q  <= dvd_d[QW-1:0];
                        rsp_rem_q   <= prem_d[QW-1:0];
                        rsp_ovf_q   <= |dvd_d[DVD_W-1:QW];
                        rsp_dbz_q   <= 1'b0;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_quot  = rsp_quot_q;
    assign rsp_rem   = rsp_rem_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_dbz   = rsp_dbz_q;
    assign busy      = (state_q != IDLE);
endmodule
